// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the memory burst controller.
//   state_e        - controller FSM states
//   RSP_FIFO_DEPTH - read response buffer depth (also the read credit pool)
//   RSP_CNT_W      - width of the response buffer occupancy/free count
//   DEF_*          - default widths for the memory interface
package mem_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_ADDR_WIDTH = 8;
    localparam int unsigned DEF_LEN_WIDTH  = 4;

    localparam int unsigned RSP_FIFO_DEPTH = 2;
    localparam int unsigned RSP_CNT_W      = $clog2(RSP_FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWrite = 2'd1,
        StRead  = 2'd2,
        StDrain = 2'd3
    } state_e;

endpackage

// File: rtl/mem_rsp_fifo.sv
// mem_rsp_fifo: small synchronous FIFO buffering memory read responses.
// Ports:
//   clk       - clock
//   clr       - synchronous clear (empties the FIFO, zeroes storage)
//   in_valid  - push request (caller guarantees space via free)
//   in_data   - push data
//   out_valid - head entry valid
//   out_ready - consumer ready; pop on out_valid & out_ready
//   out_data  - head entry, stable until popped
//   free      - number of empty slots
module mem_rsp_fifo
    import mem_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_DATA_WIDTH
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [RSP_CNT_W-1:0] free
);

    localparam int unsigned PtrW = $clog2(RSP_FIFO_DEPTH);

    logic [WIDTH-1:0]     mem_q [RSP_FIFO_DEPTH];
    logic [PtrW-1:0]      wptr_q;
    logic [PtrW-1:0]      rptr_q;
    logic [RSP_CNT_W-1:0] cnt_q;
    logic                 push;
    logic                 pop;

    assign out_valid = (cnt_q != '0);
    assign pop       = out_valid && out_ready;
    // A full FIFO can still take a push in the cycle its head is popped.
    assign push      = in_valid && ((cnt_q != RSP_CNT_W'(RSP_FIFO_DEPTH)) || pop);
    assign out_data  = mem_q[rptr_q];
    assign free      = RSP_CNT_W'(RSP_FIFO_DEPTH) - cnt_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < int'(RSP_FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wptr_q] <= in_data;
                wptr_q        <= wptr_q + PtrW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PtrW'(1);
            end
            if (push && !pop) begin
                cnt_q <= cnt_q + RSP_CNT_W'(1);
            end else if (pop && !push) begin
                cnt_q <= cnt_q - RSP_CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/mem_burst_ctrl.sv
// mem_burst_ctrl: burst sequencer in front of a single-port synchronous memory.
// Accepts a burst command, streams write beats straight to the memory or issues
// reads and returns the data through a 2-entry response FIFO with backpressure.
// Ports:
//   clk, rst                     - clock, synchronous active-high reset
//   cmd_valid/ready/wr/addr/len  - burst command (len = beats - 1)
//   wr_valid/ready/data          - write beat stream
//   rd_valid/ready/data          - read beat stream
//   busy                         - burst active or read data still buffered
//   err                          - one-cycle pulse on a rejected command
//   mem_rd/wr/addr/wdata/rdata   - memory pins (rdata valid the cycle after rd)
// Build option: define MEM_BOUNDARY_CHK_EN to reject bursts that would run past
// the top of the address space; otherwise err is tied low and bursts wrap.
module mem_burst_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned LEN_WIDTH  = DEF_LEN_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_wr,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  busy,
    output logic                  err,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int unsigned CW = RSP_CNT_W + 1;

    state_e                state_q;
    state_e                state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]  cnt_q;
    logic                  inflight_q;
    logic                  cmd_ready_q;

    logic                  cmd_fire;
    logic                  wr_fire;
    logic                  rd_issue;
    logic                  bound_err;
    logic                  drain_done;
    logic                  pop;
    logic                  fifo_valid;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic [RSP_CNT_W-1:0]  fifo_free;
    logic [CW-1:0]         avail;

`ifdef MEM_BOUNDARY_CHK_EN
    localparam int unsigned AW1 = ADDR_WIDTH + 1;
    logic [ADDR_WIDTH:0] end_addr;
    logic                err_q;

    // Carry out of the last beat address means the burst would wrap.
    assign end_addr  = {1'b0, cmd_addr} + AW1'(cmd_len);
    assign bound_err = end_addr[ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= cmd_fire && bound_err;
        end
    end
    assign err = err_q;
`else
    assign bound_err = 1'b0;
    assign err       = 1'b0;
`endif

    assign cmd_ready = cmd_ready_q;
    assign cmd_fire  = cmd_valid && cmd_ready_q;
    assign wr_ready  = (state_q == StWrite);
    assign wr_fire   = wr_valid && wr_ready;
    assign pop       = fifo_valid && rd_ready;

    // Read credit: free slots (counting the slot freed by this cycle's pop)
    // must exceed the reads already in flight.
    assign avail    = CW'(fifo_free) + CW'(pop);
    assign rd_issue = (state_q == StRead) && (avail > CW'(inflight_q));

    // Drain completes when the last buffered beat leaves this cycle.
    assign drain_done = !inflight_q &&
                        (!fifo_valid ||
                         (pop && (fifo_free == RSP_CNT_W'(RSP_FIFO_DEPTH - 1))));

    assign mem_wr    = wr_fire;
    assign mem_wdata = wr_fire ? wr_data : '0;
    assign mem_rd    = rd_issue;
    assign mem_addr  = addr_q;
    assign rd_valid  = fifo_valid;
    assign rd_data   = fifo_data;
    assign busy      = (state_q != StIdle) || fifo_valid;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_fire && !bound_err) begin
                    state_d = cmd_wr ? StWrite : StRead;
                end
            end
            StWrite: begin
                if (wr_fire && (cnt_q == '0)) begin
                    state_d = StIdle;
                end
            end
            StRead: begin
                if (rd_issue && (cnt_q == '0)) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (drain_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            cnt_q       <= '0;
            inflight_q  <= 1'b0;
            cmd_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            // Ready only once the controller is back in idle, so a command is
            // never taken while the previous burst is still finishing.
            cmd_ready_q <= (state_d == StIdle);
            inflight_q  <= rd_issue;
            if (cmd_fire) begin
                addr_q <= cmd_addr;
                cnt_q  <= cmd_len;
            end else if (wr_fire || rd_issue) begin
                addr_q <= addr_q + ADDR_WIDTH'(1);
                cnt_q  <= cnt_q - LEN_WIDTH'(1);
            end
        end
    end

    mem_rsp_fifo #(
        .WIDTH(DATA_WIDTH)
    ) u_rsp_fifo (
        .clk      (clk),
        .clr      (rst),
        .in_valid (inflight_q),
        .in_data  (mem_rdata),
        .out_valid(fifo_valid),
        .out_ready(rd_ready),
        .out_data (fifo_data),
        .free     (fifo_free)
    );

endmodule
